memory_led_bus: RTL and testbench

- Data-side memory subsystem sitting between the core's data port and the board.
- Replaces the single "any write lights the LED" flop with two regions:
  - a byte-addressable data RAM honouring the core's 3-bit write-section encoding;
  - a memory-mapped PWM LED controller with a parametrised channel count.
- Reads have fixed one-cycle latency; illegal accesses are flagged, never silently performed.

---
 rtl/memory_led_bus.sv | 148 ++++++++++++++
 tb/tb_memory_led_bus.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_led_bus.sv
`default_nettype none
// ============================================================================
// Module  : memory_led_bus
// Brief   : Data-side memory: byte-lane data RAM plus memory-mapped PWM LED block
// Revision: 1.0  initial release
// ============================================================================
module memory_led_bus #(
   parameter int unsigned MEMORY_SIZE  = 32'h1000,
   parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
   parameter int unsigned LED_CHANNELS = 3,
   parameter int unsigned PWM_WIDTH    = 8,
   parameter int unsigned PRESCALE     = 16
) (
   input  logic                    clk48,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic [31:0]             address,
   input  logic [31:0]             write_data,
   input  logic [2:0]              write_sections,
   output logic [31:0]             read_data,
   output logic                    read_valid,
   output logic                    access_error,
   output logic [LED_CHANNELS-1:0] led_n
);
   localparam int unsigned           c_WORDS     = MEMORY_SIZE / 4;
   localparam int unsigned           c_AW        = $clog2(c_WORDS);
   localparam int unsigned           c_PSW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_PSW-1:0]      c_PRESC_MAX = c_PSW'(PRESCALE - 1);
   localparam logic [PWM_WIDTH-1:0]  c_CNT_MAX   = '1;

   logic        w_is_read, w_is_byte, w_is_half, w_is_word;
   logic        w_legal, w_misaligned, w_in_ram, w_in_mmio, w_err, w_wr;
   logic [31:0] w_mmio_off;
   logic [5:0]  w_reg_idx;
   logic [3:0]  w_be;
   logic [c_AW-1:0] w_widx;
   logic [31:0] w_mmio_rdata;

   logic [31:0]          r_mem [0:c_WORDS-1];
   logic [31:0]          r_read_data;
   logic                 r_read_valid;
   logic                 r_err;
   logic [1:0]           r_ctrl;
   logic [PWM_WIDTH-1:0] r_duty   [LED_CHANNELS];
   logic [PWM_WIDTH-1:0] r_shadow [LED_CHANNELS];
   logic [PWM_WIDTH-1:0] r_cnt;
   logic [c_PSW-1:0]     r_presc;
   logic [LED_CHANNELS-1:0] r_led_n;

   logic                    w_tick, w_wrap;
   logic [PWM_WIDTH-1:0]    w_duty_nxt [LED_CHANNELS];
   logic [LED_CHANNELS-1:0] w_on;

   assign w_is_read = (write_sections == 3'b000);
   assign w_is_byte = (write_sections == 3'b001);
   assign w_is_half = (write_sections == 3'b011);
   assign w_is_word = (write_sections == 3'b111);
   assign w_legal   = w_is_read | w_is_byte | w_is_half | w_is_word;
   assign w_misaligned = (w_is_half && address[0]) || (w_is_word && (address[1:0] != 2'b00));

   assign w_in_ram   = (address < MEMORY_SIZE);
   assign w_mmio_off = address - MMIO_BASE;
   assign w_in_mmio  = (address >= MMIO_BASE) && (w_mmio_off < 32'd256);
   assign w_reg_idx  = w_mmio_off[7:2];
   assign w_widx     = address[c_AW+1:2];

   // MMIO only accepts full-word stores; narrower ones are flagged.
   assign w_err = !w_legal || w_misaligned || !(w_in_ram || w_in_mmio) ||
                  (w_in_mmio && (w_is_byte || w_is_half));
   assign w_wr  = req_valid && !reset && !w_is_read && !w_err;

   always_comb begin
      w_be = 4'b0000;
      if (w_is_word)      w_be = 4'b1111;
      else if (w_is_half) w_be = address[1] ? 4'b1100 : 4'b0011;
      else if (w_is_byte) w_be = 4'b0001 << address[1:0];
   end

   always_ff @(posedge clk48) begin
      if (w_wr && w_in_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_widx][8*b +: 8] <= write_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_mmio_rdata = '0;
      if (w_reg_idx == 6'd0)       w_mmio_rdata = {30'd0, r_ctrl};
      else if (w_reg_idx == 6'd16) w_mmio_rdata = 32'(r_cnt);
      for (int i = 0; i < LED_CHANNELS; i++) begin
         if (w_reg_idx == 6'(i + 1)) w_mmio_rdata = 32'(r_duty[i]);
      end
   end

   always_ff @(posedge clk48) begin
      if (reset) begin
         r_read_data  <= '0;
         r_read_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_read_valid <= req_valid && w_is_read;
         r_err        <= req_valid && w_err;
         if (req_valid && w_is_read)
            r_read_data <= w_err ? 32'd0 : (w_in_ram ? r_mem[w_widx] : w_mmio_rdata);
      end
   end

   assign w_tick = (r_presc == c_PRESC_MAX);
   assign w_wrap = w_tick && (r_cnt == c_CNT_MAX);

   generate
      for (genvar i = 0; i < LED_CHANNELS; i++) begin : g_chan
         // Shadow reload sees a same-edge DUTY write through the next-value mux.
         assign w_duty_nxt[i] = (w_wr && w_in_mmio && (w_reg_idx == 6'(i + 1))) ?
                                write_data[PWM_WIDTH-1:0] : r_duty[i];
         assign w_on[i] = r_ctrl[0] && (r_cnt < r_shadow[i]);
      end
   endgenerate

   always_ff @(posedge clk48) begin
      if (reset) begin
         r_presc <= '0;
         r_cnt   <= '0;
         r_ctrl  <= 2'b00;
         r_led_n <= '1;
         for (int i = 0; i < LED_CHANNELS; i++) begin
            r_duty[i]   <= '0;
            r_shadow[i] <= '0;
         end
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) r_cnt <= r_cnt + 1'b1;
         if (w_wr && w_in_mmio && (w_reg_idx == 6'd0)) r_ctrl <= write_data[1:0];
         for (int i = 0; i < LED_CHANNELS; i++) begin
            r_duty[i] <= w_duty_nxt[i];
            if (w_wrap) r_shadow[i] <= w_duty_nxt[i];
         end
         r_led_n <= ~(w_on ^ {LED_CHANNELS{r_ctrl[1]}});
      end
   end

   assign read_data    = r_read_data;
   assign read_valid   = r_read_valid;
   assign access_error = r_err;
   assign led_n        = r_led_n;
endmodule
`default_nettype wire

// File: tb/tb_memory_led_bus.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_led_bus
// Brief   : Directed self-checking bench for memory_led_bus (PRESCALE = 1)
// Revision: 1.0  initial release
// ============================================================================
module tb_memory_led_bus;
   localparam logic [31:0] c_MB = 32'h8000_0000;

   logic        clk48 = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [2:0]  write_sections = '0;
   logic [31:0] read_data;
   logic        read_valid;
   logic        access_error;
   logic [2:0]  led_n;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] model_cnt;

   memory_led_bus #(
      .MEMORY_SIZE (32'h1000),
      .MMIO_BASE   (c_MB),
      .LED_CHANNELS(3),
      .PWM_WIDTH   (8),
      .PRESCALE    (1)
   ) u_dut (
      .clk48         (clk48),
      .reset         (reset),
      .req_valid     (req_valid),
      .address       (address),
      .write_data    (write_data),
      .write_sections(write_sections),
      .read_data     (read_data),
      .read_valid    (read_valid),
      .access_error  (access_error),
      .led_n         (led_n)
   );

   always #5 clk48 = ~clk48;

   // Reference PWM counter: with PRESCALE=1 it advances every clock.
   always @(posedge clk48) begin
      if (reset) model_cnt <= 8'd0;
      else       model_cnt <= model_cnt + 8'd1;
   end

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                      output logic [31:0] rd, output logic rv, output logic er);
      req_valid = 1'b1; address = a; write_data = d; write_sections = s;
      @(posedge clk48); #1;
      req_valid = 1'b0; write_sections = 3'b000;
      rd = read_data; rv = read_valid; er = access_error;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic rv, er;
      reset = 1'b1;
      repeat (3) @(posedge clk48);
      #1;
      n_cmp++; if (led_n !== 3'b111) begin n_bad++; $display("FAIL reset_led_n: got %b expected 111", led_n); end
      n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid: got %b expected 0", read_valid); end
      n_cmp++; if (access_error !== 1'b0) begin n_bad++; $display("FAIL reset_access_error: got %b expected 0", access_error); end
      reset = 1'b0;
      bus(c_MB, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0 || rv !== 1'b1) begin n_bad++; $display("FAIL reset_ctrl: got %h/%b expected 0/1", rd, rv); end
      bus(c_MB + 32'd4, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_duty0: got %h expected 0", rd); end
   endtask

   task automatic test_ram_rw();
      logic [31:0] rd; logic rv, er;
      bus(32'h10, 32'hDEADBEEF, 3'b111, rd, rv, er);
      n_cmp++; if (er !== 1'b0 || rv !== 1'b0) begin n_bad++; $display("FAIL word_write_flags: got err=%b valid=%b expected 0/0", er, rv); end
      bus(32'h10, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rv !== 1'b1 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_read: got %h/%b expected deadbeef/1", rd, rv); end
      bus(32'h13, 32'h5A5A5A5A, 3'b001, rd, rv, er);
      bus(32'h11, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'h5AADBEEF) begin n_bad++; $display("FAIL byte_write: got %h expected 5aadbeef", rd); end
      bus(32'h12, 32'h12341234, 3'b011, rd, rv, er);
      bus(32'h10, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'h1234BEEF) begin n_bad++; $display("FAIL half_write: got %h expected 1234beef", rd); end
   endtask

   task automatic test_illegal();
      logic [31:0] rd; logic rv, er;
      bus(32'h11, 32'hFFFFFFFF, 3'b011, rd, rv, er);
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_half_misaligned: got %b expected 1", er); end
      bus(32'h12, 32'hFFFFFFFF, 3'b111, rd, rv, er);
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_word_misaligned: got %b expected 1", er); end
      bus(32'h10, 32'hFFFFFFFF, 3'b010, rd, rv, er);
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_sections_010: got %b expected 1", er); end
      bus(32'h2000, 0, 3'b000, rd, rv, er);
      n_cmp++; if (er !== 1'b1 || rv !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL err_unmapped_read: got err=%b valid=%b data=%h expected 1/1/0", er, rv, rd); end
      bus(c_MB, 32'hFFFFFFFF, 3'b001, rd, rv, er);
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_mmio_byte: got %b expected 1", er); end
      @(posedge clk48); #1;
      n_cmp++; if (access_error !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b expected 0", access_error); end
      bus(32'h10, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'h1234BEEF || er !== 1'b0) begin n_bad++; $display("FAIL err_mem_unchanged: got %h err=%b expected 1234beef/0", rd, er); end
      bus(c_MB, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL err_ctrl_unchanged: got %h expected 0", rd); end
   endtask

   task automatic test_mmio_misc();
      logic [31:0] rd; logic rv, er; logic [7:0] exp;
      bus(c_MB + 32'h80, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0 || er !== 1'b0 || rv !== 1'b1) begin n_bad++; $display("FAIL mmio_hole_read: got %h err=%b valid=%b expected 0/0/1", rd, er, rv); end
      bus(c_MB + 32'h40, 32'h55, 3'b111, rd, rv, er);
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL status_write_err: got %b expected 0", er); end
      exp = model_cnt;
      bus(c_MB + 32'h40, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== {24'd0, exp}) begin n_bad++; $display("FAIL status_read: got %h expected %h", rd, {24'd0, exp}); end
   endtask

   task automatic test_pwm();
      logic [31:0] rd; logic rv, er;
      int lo0a, lo1a, lo2a, lo0b, lo1b, lo2b;
      bit found, wrote, pend;
      bus(c_MB,          32'd1,   3'b111, rd, rv, er);
      bus(c_MB + 32'd4,  32'd64,  3'b111, rd, rv, er);
      bus(c_MB + 32'd8,  32'd0,   3'b111, rd, rv, er);
      bus(c_MB + 32'd12, 32'd255, 3'b111, rd, rv, er);
      found = 0;
      for (int k = 0; k < 600 && !found; k++) begin
         @(posedge clk48); #1;
         if (model_cnt == 8'd0) found = 1;
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL pwm_wrap_timeout: got no wrap expected wrap within 600 cycles"); end
      lo0a = 0; lo1a = 0; lo2a = 0; lo0b = 0; lo1b = 0; lo2b = 0;
      wrote = 0; pend = 0;
      for (int i = 1; i <= 512; i++) begin
         @(posedge clk48); #1;
         if (pend) begin req_valid = 1'b0; write_sections = 3'b000; pend = 0; end
         if (i <= 256) begin
            lo0a += (led_n[0] == 1'b0); lo1a += (led_n[1] == 1'b0); lo2a += (led_n[2] == 1'b0);
         end else begin
            lo0b += (led_n[0] == 1'b0); lo1b += (led_n[1] == 1'b0); lo2b += (led_n[2] == 1'b0);
         end
         if (!wrote && i <= 256 && model_cnt == 8'd100) begin
            req_valid = 1'b1; address = c_MB + 32'd4; write_data = 32'd200; write_sections = 3'b111;
            wrote = 1; pend = 1;
         end
      end
      n_cmp++; if (lo0a != 64)  begin n_bad++; $display("FAIL pwm_ch0_period1: got %0d expected 64", lo0a); end
      n_cmp++; if (lo1a != 0)   begin n_bad++; $display("FAIL pwm_ch1_period1: got %0d expected 0", lo1a); end
      n_cmp++; if (lo2a != 255) begin n_bad++; $display("FAIL pwm_ch2_period1: got %0d expected 255", lo2a); end
      n_cmp++; if (lo0b != 200) begin n_bad++; $display("FAIL pwm_ch0_period2: got %0d expected 200", lo0b); end
      n_cmp++; if (lo1b != 0)   begin n_bad++; $display("FAIL pwm_ch1_period2: got %0d expected 0", lo1b); end
      n_cmp++; if (lo2b != 255) begin n_bad++; $display("FAIL pwm_ch2_period2: got %0d expected 255", lo2b); end
      bus(c_MB + 32'd4, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd200) begin n_bad++; $display("FAIL duty0_readback: got %h expected c8", rd); end
   endtask

   task automatic test_invert_reset();
      logic [31:0] rd; logic rv, er; int lit;
      bus(c_MB, 32'd3, 3'b111, rd, rv, er);
      repeat (2) @(posedge clk48);
      lit = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk48); #1;
         lit += (led_n[1] == 1'b0);
      end
      n_cmp++; if (lit != 20) begin n_bad++; $display("FAIL invert_ch1_lit: got %0d expected 20", lit); end
      reset = 1'b1;
      req_valid = 1'b1; address = 32'h10; write_sections = 3'b000;
      @(posedge clk48); #1;
      req_valid = 1'b0; reset = 1'b0;
      n_cmp++; if (led_n !== 3'b111) begin n_bad++; $display("FAIL midreset_led_n: got %b expected 111", led_n); end
      n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_read_valid: got %b expected 0", read_valid); end
      bus(c_MB + 32'h40, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_status: got %h expected 0", rd); end
      bus(c_MB, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_ctrl: got %h expected 0", rd); end
      bus(32'h10, 0, 3'b000, rd, rv, er);
      n_cmp++; if (rd !== 32'h1234BEEF) begin n_bad++; $display("FAIL midreset_ram_kept: got %h expected 1234beef", rd); end
   endtask

   initial begin
      test_reset();
      test_ram_rw();
      test_illegal();
      test_mmio_misc();
      test_pwm();
      test_invert_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
